// File: rtl/stl_dnsizer.sv
// Wide-to-narrow stream serializer: one DATA_W beat in, 1..RATIO OUT_W beats out.
// Slices leave least-significant first; a new wide beat can load on the last-slice handshake.
module stl_dnsizer #(
  parameter int DATA_W = 1024,
  parameter int OUT_W  = 128,
  localparam int RATIO = DATA_W / OUT_W,
  localparam int CNT_W = $clog2(RATIO)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upreq_vld_i,
  input  logic [DATA_W-1:0] upreq_dat_i,
  input  logic [CNT_W-1:0]  upreq_len_i,
  output logic              upreq_rdy_o,
  output logic              dnreq_vld_o,
  output logic [OUT_W-1:0]  dnreq_dat_o,
  output logic              dnreq_last_o,
  output logic [CNT_W-1:0]  dnreq_idx_o,
  input  logic              dnreq_rdy_i
);

  logic [DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              last, hsk_i, hsk_o;
  logic [OUT_W-1:0]  slc [RATIO];

  for (genvar k = 0; k < RATIO; k++) begin : g_slc
    assign slc[k] = dat_q[k*OUT_W +: OUT_W];
  end

  assign last  = vld_q & (cnt_q == len_q);
  assign hsk_o = vld_q & dnreq_rdy_i;
  // Ready looks through to dnreq_rdy_i so wide beats chain with no bubble.
  assign upreq_rdy_o = ~vld_q | (hsk_o & last);
  assign hsk_i = upreq_vld_i & upreq_rdy_o;

  assign dnreq_vld_o  = vld_q;
  assign dnreq_idx_o  = cnt_q;
  assign dnreq_last_o = last;
  assign dnreq_dat_o  = vld_q ? slc[cnt_q] : '0;

  always_comb begin
    dat_d = dat_q;
    len_d = len_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (hsk_i) begin
      dat_d = upreq_dat_i;
      len_d = upreq_len_i;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (hsk_o) begin
      if (last) begin
        vld_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

endmodule

// File: tb/tb_stl_dnsizer.sv
// Bench for stl_dnsizer: vector table, directed corner sequences,
// and random traffic against a queue-of-slices reference model.
module tb_stl_dnsizer;

  localparam int DATA_W = 1024;
  localparam int OUT_W  = 128;
  localparam int RATIO  = DATA_W / OUT_W;
  localparam int CNT_W  = $clog2(RATIO);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              upreq_vld_i;
  logic [DATA_W-1:0] upreq_dat_i;
  logic [CNT_W-1:0]  upreq_len_i;
  logic              upreq_rdy_o;
  logic              dnreq_vld_o;
  logic [OUT_W-1:0]  dnreq_dat_o;
  logic              dnreq_last_o;
  logic [CNT_W-1:0]  dnreq_idx_o;
  logic              dnreq_rdy_i;

  stl_dnsizer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upreq_vld_i (upreq_vld_i),
    .upreq_dat_i (upreq_dat_i),
    .upreq_len_i (upreq_len_i),
    .upreq_rdy_o (upreq_rdy_o),
    .dnreq_vld_o (dnreq_vld_o),
    .dnreq_dat_o (dnreq_dat_o),
    .dnreq_last_o(dnreq_last_o),
    .dnreq_idx_o (dnreq_idx_o),
    .dnreq_rdy_i (dnreq_rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [CNT_W-1:0] i;
    logic             l;
  } nb_t;

  typedef struct {
    logic             uv;
    logic [CNT_W-1:0] len;
    logic             dr;
    logic [7:0]       seed;
    logic             ev;
    logic [CNT_W-1:0] ei;
    logic             el;
    logic             eu;
  } vec_t;

  nb_t  q[$];
  vec_t tv[13];
  int   total = 0;
  int   passed = 0;
  logic cur_r, cur_uv, cur_dr, m_rdy;
  logic [CNT_W-1:0]  cur_len;
  logic [DATA_W-1:0] cur_dat;

  function automatic void chk(string n, logic [OUT_W-1:0] a,
                              logic [OUT_W-1:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] s);
    logic [DATA_W-1:0] v;
    for (int k = 0; k < RATIO; k++)
      v[k*OUT_W +: OUT_W] = {(OUT_W/8){8'(s + 8'h11 * k)}};
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_dat();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic r, input logic uv,
                       input logic [CNT_W-1:0] len,
                       input logic [DATA_W-1:0] d, input logic dr);
    rst_n = r; upreq_vld_i = uv; upreq_len_i = len;
    upreq_dat_i = d; dnreq_rdy_i = dr;
    cur_r = r; cur_uv = uv; cur_len = len; cur_dat = d; cur_dr = dr;
    m_rdy = (q.size() == 0) || (q.size() == 1 && dr);
    #1;
  endtask

  task automatic check_model();
    chk("vld", OUT_W'(dnreq_vld_o), OUT_W'(q.size() != 0));
    chk("rdy", OUT_W'(upreq_rdy_o), OUT_W'(m_rdy));
    if (q.size() != 0) begin
      chk("dat", dnreq_dat_o, q[0].d);
      chk("idx", OUT_W'(dnreq_idx_o), OUT_W'(q[0].i));
      chk("last", OUT_W'(dnreq_last_o), OUT_W'(q[0].l));
    end else begin
      chk("dat0", dnreq_dat_o, '0);
      chk("idx0", OUT_W'(dnreq_idx_o), '0);
      chk("last0", OUT_W'(dnreq_last_o), '0);
    end
  endtask

  task automatic tick();
    nb_t b;
    @(posedge clk);
    if (!cur_r) begin
      q.delete();
    end else begin
      if (q.size() != 0 && cur_dr) void'(q.pop_front());
      if (cur_uv && m_rdy)
        for (int k = 0; k <= int'(cur_len); k++) begin
          b.d = cur_dat[k*OUT_W +: OUT_W];
          b.i = CNT_W'(k);
          b.l = (k == int'(cur_len));
          q.push_back(b);
        end
    end
    #1;
  endtask

  initial begin
    int hs;
    int n;
    tv[0]  = '{1'b1, 3'd3, 1'b1, 8'h10, 1'b0, 3'd0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 3'd0, 1'b1, 8'h50, 1'b1, 3'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 3'd0, 1'b1, 8'h50, 1'b1, 3'd1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 3'd0, 1'b1, 8'h50, 1'b1, 3'd2, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 3'd0, 1'b1, 8'h50, 1'b1, 3'd3, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 3'd5, 1'b1, 8'h99, 1'b1, 3'd0, 1'b1, 1'b1};
    tv[6]  = '{1'b0, 3'd5, 1'b1, 8'h99, 1'b0, 3'd0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 3'd0, 1'b0, 8'h70, 1'b0, 3'd0, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 3'd2, 1'b0, 8'h33, 1'b1, 3'd0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 3'd2, 1'b0, 8'h33, 1'b1, 3'd0, 1'b1, 1'b0};
    tv[10] = '{1'b0, 3'd2, 1'b0, 8'h33, 1'b1, 3'd0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 3'd0, 1'b1, 8'h33, 1'b1, 3'd0, 1'b1, 1'b1};
    tv[12] = '{1'b0, 3'd0, 1'b1, 8'h33, 1'b0, 3'd0, 1'b0, 1'b1};

    // Reset with upstream valid held high
    drive(1'b0, 1'b1, 3'd7, pat(8'h00), 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 3'd7, pat(8'h00), 1'b1);
      chk("rst_vld", OUT_W'(dnreq_vld_o), '0);
      chk("rst_rdy", OUT_W'(upreq_rdy_o), OUT_W'(1));
      check_model();
      tick();
    end

    // Full-width beat, first edge after reset accepts it
    drive(1'b1, 1'b1, 3'd7, pat(8'h00), 1'b1);
    check_model();
    tick();
    for (int k = 0; k < RATIO; k++) begin
      drive(1'b1, 1'b0, 3'd0, '0, 1'b1);
      chk("full_idx", OUT_W'(dnreq_idx_o), OUT_W'(k));
      chk("full_dat", dnreq_dat_o, {(OUT_W/8){8'(8'h11 * k)}});
      chk("full_last", OUT_W'(dnreq_last_o), OUT_W'(k == RATIO-1));
      chk("full_rdy", OUT_W'(upreq_rdy_o), OUT_W'(k == RATIO-1));
      check_model();
      tick();
    end

    // Vector table: back-to-back len3/len0, then len0 under a 3-cycle stall
    for (int t = 0; t < 13; t++) begin
      drive(1'b1, tv[t].uv, tv[t].len, pat(tv[t].seed), tv[t].dr);
      chk($sformatf("tv%0d_vld", t), OUT_W'(dnreq_vld_o), OUT_W'(tv[t].ev));
      chk($sformatf("tv%0d_idx", t), OUT_W'(dnreq_idx_o), OUT_W'(tv[t].ei));
      chk($sformatf("tv%0d_last", t), OUT_W'(dnreq_last_o), OUT_W'(tv[t].el));
      chk($sformatf("tv%0d_rdy", t), OUT_W'(upreq_rdy_o), OUT_W'(tv[t].eu));
      check_model();
      tick();
    end

    // len=5 beat under random downstream stalls
    hs = 0;
    drive(1'b1, 1'b1, 3'd5, rnd_dat(), 1'($urandom));
    check_model();
    tick();
    n = 0;
    while (q.size() != 0 && n < 200) begin
      drive(1'b1, 1'b0, 3'd0, '0, 1'($urandom));
      if (dnreq_vld_o && dnreq_rdy_i) hs++;
      check_model();
      tick();
      n++;
    end
    chk("stall_bound", OUT_W'(n < 200), OUT_W'(1));
    chk("stall_hs", OUT_W'(hs), OUT_W'(6));

    // Reset pulse while slice 2 of a len=7 beat is presented
    drive(1'b1, 1'b1, 3'd7, pat(8'h40), 1'b1);
    check_model();
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 3'd0, '0, 1'b1);
      check_model();
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, '0, 1'b0);
    chk("mid_idx", OUT_W'(dnreq_idx_o), OUT_W'(2));
    check_model();
    tick();
    drive(1'b1, 1'b1, 3'd3, pat(8'h80), 1'b1);
    chk("mid_vld", OUT_W'(dnreq_vld_o), '0);
    check_model();
    tick();
    drive(1'b1, 1'b0, 3'd0, '0, 1'b1);
    chk("mid_new_idx", OUT_W'(dnreq_idx_o), '0);
    chk("mid_new_dat", dnreq_dat_o, {(OUT_W/8){8'h80}});
    check_model();
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 64) != 0, 1'($urandom), CNT_W'($urandom),
            rnd_dat(), ($urandom % 4) != 0);
      check_model();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
